// File: rtl/axi_mem_responder_pkg.sv
// Shared AXI definitions for the scratchpad responder: response codes and
// the error classification used for both read and write address phases.
package axi_mem_responder_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Decode error beats slave error; only single-beat in-window accesses are served.
   function automatic logic [1:0] axi_err_resp(input logic in_range, input logic [7:0] len);
      logic [1:0] resp;
      if (!in_range) begin
         resp = RESP_DECERR;
      end else if (len != 8'd0) begin
         resp = RESP_SLVERR;
      end else begin
         resp = RESP_OKAY;
      end
      return resp;
   endfunction

endpackage

// File: rtl/axi_mem_responder.sv
// Single-beat AXI4 slave in front of a 1-cycle-latency single-port SRAM.
// One transaction in flight; read/write arbitration alternates on contention.
//
// Handshake semantics: a transfer happens on a rising clk edge where valid and
// ready are both high. Outputs held by this block stay stable while valid is
// high and ready is low. Ready outputs are decoded from registered state; only
// ar_ready_o/aw_ready_o look at the incoming valids, through Idle arbitration.
module axi_mem_responder
   import axi_mem_responder_pkg::*;
#(
   parameter logic [63:0] MEM_START = 64'h8000_0000,
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned ID_WIDTH  = 4,
   localparam int unsigned AW       = $clog2(MEM_WORDS)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   // read address
   input  logic                ar_valid_i,
   output logic                ar_ready_o,
   input  logic [ID_WIDTH-1:0] ar_id_i,
   input  logic [63:0]         ar_addr_i,
   input  logic [7:0]          ar_len_i,
   input  logic [2:0]          ar_size_i,
   // read data
   output logic                r_valid_o,
   input  logic                r_ready_i,
   output logic [ID_WIDTH-1:0] r_id_o,
   output logic [63:0]         r_data_o,
   output logic [1:0]          r_resp_o,
   output logic                r_last_o,
   // write address
   input  logic                aw_valid_i,
   output logic                aw_ready_o,
   input  logic [ID_WIDTH-1:0] aw_id_i,
   input  logic [63:0]         aw_addr_i,
   input  logic [7:0]          aw_len_i,
   input  logic [2:0]          aw_size_i,
   // write data
   input  logic                w_valid_i,
   output logic                w_ready_o,
   input  logic [63:0]         w_data_i,
   input  logic [7:0]          w_strb_i,
   input  logic                w_last_i,
   // write response
   output logic                b_valid_o,
   input  logic                b_ready_i,
   output logic [ID_WIDTH-1:0] b_id_o,
   output logic [1:0]          b_resp_o,
   // SRAM port
   output logic                sram_req_o,
   output logic                sram_we_o,
   output logic [AW-1:0]       sram_addr_o,
   output logic [63:0]         sram_wdata_o,
   output logic [7:0]          sram_be_o,
   input  logic [63:0]         sram_rdata_i,
   // debug
   output logic [2:0]          dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_READ_MEM   = 3'd1,
      S_READ_WAIT  = 3'd2,
      S_READ_RESP  = 3'd3,
      S_WRITE_DATA = 3'd4,
      S_WRITE_MEM  = 3'd5,
      S_WRITE_RESP = 3'd6
   } state_e;

   // Exclusive upper bound of the window, computed in 64 bits without wrap.
   localparam logic [63:0] MEM_END = MEM_START + (64'(MEM_WORDS) << 3);

   state_e                state_q;
   logic                  last_rd_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [AW-1:0]         widx_q;
   logic [7:0]            cnt_q;
   logic [1:0]            resp_q;
   logic [63:0]           data_q;
   logic [7:0]            strb_q;

   logic                  ar_win;
   logic                  aw_win;
   logic                  ar_in;
   logic                  aw_in;
   logic [63:0]           ar_off;
   logic [63:0]           aw_off;

   // Window decode and byte offset of both incoming addresses.
   always_comb begin
      ar_in  = (ar_addr_i >= MEM_START) && (ar_addr_i < MEM_END);
      aw_in  = (aw_addr_i >= MEM_START) && (aw_addr_i < MEM_END);
      ar_off = ar_addr_i - MEM_START;
      aw_off = aw_addr_i - MEM_START;
   end

   // Fair arbitration: a sole requester wins; on contention the side that did not go last wins.
   always_comb begin
      ar_win = ar_valid_i && (!aw_valid_i || !last_rd_q);
      aw_win = aw_valid_i && (!ar_valid_i ||  last_rd_q);
   end

   // Transaction FSM with all latched transaction fields.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         last_rd_q <= 1'b0;
         id_q      <= '0;
         widx_q    <= '0;
         cnt_q     <= '0;
         resp_q    <= RESP_OKAY;
         data_q    <= '0;
         strb_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ar_win) begin
                  id_q      <= ar_id_i;
                  widx_q    <= ar_off[AW+2:3];
                  cnt_q     <= ar_len_i;
                  last_rd_q <= 1'b1;
                  data_q    <= '0;
                  resp_q    <= axi_err_resp(ar_in, ar_len_i);
                  state_q   <= (ar_in && ar_len_i == 8'd0) ? S_READ_MEM : S_READ_RESP;
               end else if (aw_win) begin
                  id_q      <= aw_id_i;
                  widx_q    <= aw_off[AW+2:3];
                  cnt_q     <= aw_len_i;
                  last_rd_q <= 1'b0;
                  resp_q    <= axi_err_resp(aw_in, aw_len_i);
                  state_q   <= S_WRITE_DATA;
               end
            end
            S_READ_MEM: begin
               state_q <= S_READ_WAIT;
            end
            S_READ_WAIT: begin
               data_q  <= sram_rdata_i;
               state_q <= S_READ_RESP;
            end
            S_READ_RESP: begin
               if (r_ready_i) begin
                  if (cnt_q == 8'd0) begin
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q - 8'd1;
                  end
               end
            end
            S_WRITE_DATA: begin
               if (w_valid_i) begin
                  if (cnt_q == 8'd0) begin
                     data_q  <= w_data_i;
                     strb_q  <= w_strb_i;
                     state_q <= (resp_q == RESP_OKAY) ? S_WRITE_MEM : S_WRITE_RESP;
                  end else begin
                     cnt_q <= cnt_q - 8'd1;
                  end
               end
            end
            S_WRITE_MEM: begin
               state_q <= S_WRITE_RESP;
            end
            S_WRITE_RESP: begin
               if (b_ready_i) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Channel outputs decoded from registered state and latched fields.
   always_comb begin
      ar_ready_o   = (state_q == S_IDLE) && ar_win;
      aw_ready_o   = (state_q == S_IDLE) && aw_win;
      r_valid_o    = (state_q == S_READ_RESP);
      r_id_o       = id_q;
      r_data_o     = data_q;
      r_resp_o     = resp_q;
      r_last_o     = (state_q == S_READ_RESP) && (cnt_q == 8'd0);
      w_ready_o    = (state_q == S_WRITE_DATA);
      b_valid_o    = (state_q == S_WRITE_RESP);
      b_id_o       = id_q;
      b_resp_o     = resp_q;
      sram_req_o   = (state_q == S_READ_MEM) || (state_q == S_WRITE_MEM);
      sram_we_o    = (state_q == S_WRITE_MEM);
      sram_addr_o  = widx_q;
      sram_wdata_o = data_q;
      sram_be_o    = (state_q == S_WRITE_MEM) ? strb_q : 8'h00;
      dbg_state_o  = state_q;
   end

   // Size is not checked and the beat count comes from len, so these are unused.
   logic unused_ok;
   assign unused_ok = ^{ar_size_i, aw_size_i, w_last_i,
                        ar_off[63:AW+3], ar_off[2:0], aw_off[63:AW+3], aw_off[2:0]};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder with a behavioural SRAM, expected
// queues for R, B and SRAM accesses, and negedge monitors that pop them.
module tb_axi_mem_responder;

   localparam logic [1:0] OK  = 2'b00;
   localparam logic [1:0] SLV = 2'b10;
   localparam logic [1:0] DEC = 2'b11;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        ar_valid, ar_ready;
   logic [3:0]  ar_id;
   logic [63:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic        r_valid, r_ready;
   logic [3:0]  r_id;
   logic [63:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;
   logic        aw_valid, aw_ready;
   logic [3:0]  aw_id;
   logic [63:0] aw_addr;
   logic [7:0]  aw_len;
   logic [2:0]  aw_size;
   logic        w_valid, w_ready;
   logic [63:0] w_data;
   logic [7:0]  w_strb;
   logic        w_last;
   logic        b_valid, b_ready;
   logic [3:0]  b_id;
   logic [1:0]  b_resp;
   logic        sram_req, sram_we;
   logic [9:0]  sram_addr;
   logic [63:0] sram_wdata;
   logic [7:0]  sram_be;
   logic [63:0] sram_rdata;
   logic [2:0]  dbg_state;

   logic [63:0] mem [1024];
   logic        mem_init;

   logic [70:0] r_q[$];   // {id, data, resp, last}
   logic [5:0]  b_q[$];   // {id, resp}
   logic [82:0] s_q[$];   // {we, addr, be, wdata}
   logic        ord_q[$]; // 0 = AR won, 1 = AW won

   int checks = 0;
   int errors = 0;

   axi_mem_responder dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id),
      .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_size_i(ar_size),
      .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id),
      .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
      .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
      .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_size_i(aw_size),
      .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
      .w_strb_i(w_strb), .w_last_i(w_last),
      .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
      .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
      .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata),
      .dbg_state_o(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // behavioural 1-cycle SRAM with byte enables
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 64'd0;
         mem[1]    <= 64'hDEAD_BEEF_0123_4567;
         mem[2]    <= 64'hAAAA_BBBB_CCCC_DDDD;
         mem[1023] <= 64'hCAFE_F00D_0000_1023;
      end else if (sram_req) begin
         if (sram_we) begin
            for (int b = 0; b < 8; b++)
               if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitors: pop expected entries whenever the DUT presents a transfer
   always @(negedge clk) begin
      if (rst_ni === 1'b1) begin
         if (r_valid && r_ready) begin
            if (r_q.size() == 0) chk("r_unexpected", {r_id, r_data, r_resp, r_last}, 0);
            else chk("r_beat", {r_id, r_data, r_resp, r_last}, r_q.pop_front());
         end
         if (b_valid && b_ready) begin
            if (b_q.size() == 0) chk("b_unexpected", {b_id, b_resp}, 0);
            else chk("b_resp", {b_id, b_resp}, b_q.pop_front());
         end
         if (sram_req === 1'b1) begin
            if (s_q.size() == 0) chk("sram_unexpected", 1, 0);
            else chk("sram_access",
                     {sram_we, sram_addr, sram_we ? sram_be : 8'h00, sram_we ? sram_wdata : 64'd0},
                     s_q.pop_front());
         end
         if (ar_valid && ar_ready) ord_q.push_back(1'b0);
         if (aw_valid && aw_ready) ord_q.push_back(1'b1);
      end
   end

   // driver tasks: called right after a posedge, return #1 after the handshake edge
   task automatic ar_send(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
      int n = 0;
      ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = 3'd3;
      do begin @(negedge clk); n++; end while (!ar_ready && n < 60);
      if (!ar_ready) chk("ar_timeout", 0, 1);
      @(posedge clk); #1;
      ar_valid = 1'b0;
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
      int n = 0;
      aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3'd3;
      do begin @(negedge clk); n++; end while (!aw_ready && n < 60);
      if (!aw_ready) chk("aw_timeout", 0, 1);
      @(posedge clk); #1;
      aw_valid = 1'b0;
   endtask

   task automatic w_send(input logic [63:0] data, input logic [7:0] strb);
      int n = 0;
      w_valid = 1'b1; w_data = data; w_strb = strb; w_last = 1'b0;
      do begin @(negedge clk); n++; end while (!w_ready && n < 60);
      if (!w_ready) chk("w_timeout", 0, 1);
      @(posedge clk); #1;
      w_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((r_q.size() != 0 || b_q.size() != 0 || s_q.size() != 0 || dbg_state != 3'd0) && n < 300) begin
         @(negedge clk); n++;
      end
      if (n >= 300) chk("idle_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   function automatic logic [82:0] s_rd(input logic [9:0] a);
      return {1'b0, a, 8'h00, 64'd0};
   endfunction

   function automatic logic [82:0] s_wr(input logic [9:0] a, input logic [7:0] be, input logic [63:0] d);
      return {1'b1, a, be, d};
   endfunction

   // main stimulus
   initial begin
      logic [3:0] ord;
      int         stray;
      rst_ni = 1'b0; mem_init = 1'b1;
      ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0;
      aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0;
      w_valid = 0; w_data = 0; w_strb = 0; w_last = 0;
      r_ready = 1'b1; b_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", {ar_ready, aw_ready, r_valid, w_ready, b_valid, sram_req, sram_we}, 7'd0);
      chk("rst_data", {r_data, r_id, r_resp, r_last, b_id, b_resp, sram_addr, sram_be}, 0);
      chk("rst_state", dbg_state, 3'd0);
      @(posedge clk); #1;
      mem_init = 1'b0; rst_ni = 1'b1;
      @(posedge clk); #1;

      // single-beat read of word 1 with latency checks
      s_q.push_back(s_rd(10'd1));
      r_q.push_back({4'd3, 64'hDEAD_BEEF_0123_4567, OK, 1'b1});
      ar_send(4'd3, 64'h8000_0008, 8'd0);
      @(negedge clk);
      chk("rd_sram_t1", {sram_req, sram_we, sram_addr}, {1'b1, 1'b0, 10'd1});
      @(negedge clk);
      chk("rd_rvalid_t2", r_valid, 1'b0);
      @(negedge clk);
      chk("rd_rvalid_t3", r_valid, 1'b1);
      wait_idle();

      // partial write to word 2, then read it back
      s_q.push_back(s_wr(10'd2, 8'h0F, 64'h1111_2222_3333_4444));
      b_q.push_back({4'd5, OK});
      aw_send(4'd5, 64'h8000_0010, 8'd0);
      w_send(64'h1111_2222_3333_4444, 8'h0F);
      @(negedge clk);
      chk("wr_sram_t2", {sram_req, sram_we}, 2'b11);
      @(negedge clk);
      chk("wr_bvalid_t3", b_valid, 1'b1);
      wait_idle();
      s_q.push_back(s_rd(10'd2));
      r_q.push_back({4'd6, 64'hAAAA_BBBB_3333_4444, OK, 1'b1});
      ar_send(4'd6, 64'h8000_0010, 8'd0);
      wait_idle();

      // a write so the next contention is won by the read
      s_q.push_back(s_wr(10'd3, 8'hFF, 64'h0102_0304_0506_0708));
      b_q.push_back({4'd7, OK});
      aw_send(4'd7, 64'h8000_0018, 8'd0);
      w_send(64'h0102_0304_0506_0708, 8'hFF);
      wait_idle();

      // contention twice in a row: expect R, W, R, W
      ord_q.delete();
      s_q.push_back(s_rd(10'd3));
      s_q.push_back(s_wr(10'd4, 8'hFF, 64'h5555_6666_7777_8888));
      s_q.push_back(s_rd(10'd4));
      s_q.push_back(s_wr(10'd5, 8'hF0, 64'h9999_AAAA_BBBB_CCCC));
      r_q.push_back({4'd1, 64'h0102_0304_0506_0708, OK, 1'b1});
      r_q.push_back({4'd1, 64'h5555_6666_7777_8888, OK, 1'b1});
      b_q.push_back({4'd2, OK});
      b_q.push_back({4'd2, OK});
      fork
         begin
            ar_send(4'd1, 64'h8000_0018, 8'd0);
            ar_send(4'd1, 64'h8000_0020, 8'd0);
         end
         begin
            aw_send(4'd2, 64'h8000_0020, 8'd0);
            w_send(64'h5555_6666_7777_8888, 8'hFF);
            aw_send(4'd2, 64'h8000_0028, 8'd0);
            w_send(64'h9999_AAAA_BBBB_CCCC, 8'hF0);
         end
      join
      wait_idle();
      chk("arb_count", ord_q.size(), 4);
      ord = 4'hF;
      if (ord_q.size() == 4) ord = {ord_q[0], ord_q[1], ord_q[2], ord_q[3]};
      chk("arb_order", ord, 4'b0101);

      // last word of the window is in range
      s_q.push_back(s_rd(10'd1023));
      r_q.push_back({4'd8, 64'hCAFE_F00D_0000_1023, OK, 1'b1});
      ar_send(4'd8, 64'h8000_1FF8, 8'd0);
      wait_idle();

      // out-of-range read just below the window
      r_q.push_back({4'd9, 64'd0, DEC, 1'b1});
      ar_send(4'd9, 64'h7FFF_FFF8, 8'd0);
      @(negedge clk);
      chk("err_rd_t1", {r_valid, sram_req}, 2'b10);
      wait_idle();

      // out-of-range write just above the window
      b_q.push_back({4'hA, DEC});
      aw_send(4'hA, 64'h8000_2000, 8'd0);
      w_send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      wait_idle();

      // burst read in range: four SLVERR beats, last on the fourth
      for (int i = 0; i < 4; i++) r_q.push_back({4'd4, 64'd0, SLV, (i == 3)});
      ar_send(4'd4, 64'h8000_0000, 8'd3);
      wait_idle();

      // burst read out of range: DECERR takes precedence
      for (int i = 0; i < 3; i++) r_q.push_back({4'hC, 64'd0, DEC, (i == 2)});
      ar_send(4'hC, 64'h9000_0000, 8'd2);
      wait_idle();

      // burst write: two beats accepted, one SLVERR response
      b_q.push_back({4'hB, SLV});
      aw_send(4'hB, 64'h8000_0000, 8'd1);
      w_send(64'h1234, 8'hFF);
      w_send(64'h5678, 8'hFF);
      @(negedge clk);
      chk("wr_burst_resp", {w_ready, b_valid}, 2'b01);
      wait_idle();

      // r_ready held low: beat must stay put
      r_ready = 1'b0;
      s_q.push_back(s_rd(10'd1));
      r_q.push_back({4'd2, 64'hDEAD_BEEF_0123_4567, OK, 1'b1});
      ar_send(4'd2, 64'h8000_0008, 8'd0);
      begin
         int n = 0;
         while (!r_valid && n < 20) begin @(negedge clk); n++; end
         chk("stall_rvalid_seen", r_valid, 1'b1);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_hold", {r_valid, r_data}, {1'b1, 64'hDEAD_BEEF_0123_4567});
      end
      @(posedge clk); #1;
      r_ready = 1'b1;
      wait_idle();

      // reset while waiting for write data: transaction is dropped
      aw_send(4'd3, 64'h8000_0030, 8'd0);
      @(negedge clk);
      chk("wdata_state", w_ready, 1'b1);
      @(posedge clk); #1;
      rst_ni = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_outputs", {ar_ready, aw_ready, r_valid, w_ready, b_valid, sram_req, sram_we, dbg_state}, 10'd0);
      @(posedge clk); #1;
      rst_ni = 1'b1;
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (b_valid || sram_req) stray++;
      end
      chk("midrst_no_b", stray, 0);
      @(posedge clk); #1;
      s_q.push_back(s_rd(10'd6));
      r_q.push_back({4'd5, 64'd0, OK, 1'b1});
      ar_send(4'd5, 64'h8000_0030, 8'd0);
      wait_idle();

      chk("queues_drained", {r_q.size(), b_q.size(), s_q.size()}, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
